// File: rtl/lbus_initiator_pkg.sv
// Shared definitions for the local-bus initiator: size codes, we encodings,
// FSM states, the CLINT window and the store-data lane replication helper.
package lbus_initiator_pkg;

  localparam logic [1:0] LBUS_SZ_BYTE = 2'b00;
  localparam logic [1:0] LBUS_SZ_HALF = 2'b01;
  localparam logic [1:0] LBUS_SZ_WORD = 2'b10;
  localparam logic [1:0] LBUS_SZ_RSVD = 2'b11;

  localparam logic [2:0] LBUS_WE_WORD = 3'b110;
  localparam logic [2:0] LBUS_WE_HALF = 3'b101;
  localparam logic [2:0] LBUS_WE_BYTE = 3'b100;

  localparam logic [15:0] CLINT_BASE_HI = 16'h0200;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } lbus_state_e;

  // Responders pick their own lane, so narrow stores are copied to every lane.
  function automatic logic [31:0] lbus_replicate(input logic [31:0] d,
                                                 input logic [1:0]  size);
    logic [31:0] r;
    case (size)
      LBUS_SZ_BYTE: r = {4{d[7:0]}};
      LBUS_SZ_HALF: r = {2{d[15:0]}};
      default:      r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lbus_load_align.sv
// Load data alignment: lane extraction by byte offset, then sign or zero
// extension. Purely combinational so the data-memory path can reuse it.
module lbus_load_align
  import lbus_initiator_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_sign;
  logic        half_sign;

  // Half selects on offset[1] only, which aligns a misaligned half down.
  assign byte_lane = data[{offset, 3'b000} +: 8];
  assign half_lane = data[{offset[1], 4'b0000} +: 16];
  assign byte_sign = byte_lane[7] & ~is_unsigned;
  assign half_sign = half_lane[15] & ~is_unsigned;

  always_comb begin
    result = data;
    case (size)
      LBUS_SZ_BYTE: result = {{(XLEN-8){byte_sign}}, byte_lane};
      LBUS_SZ_HALF: result = {{(XLEN-16){half_sign}}, half_lane};
      default:      result = data;
    endcase
  end

endmodule

// File: rtl/lbus_initiator.sv
// Local-bus initiator: one LSU load/store at a time becomes a sel/addr/we/wdata
// cycle. Optional macro LBUS_INITIATOR_MISALIGN_ERR_EN turns misaligned half/word into errors.
module lbus_initiator
  import lbus_initiator_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter logic [15:0] BASE_HI = CLINT_BASE_HI,
  parameter int          RD_LAT  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            sel,
  output logic [15:0]     addr,
  output logic [2:0]      we,
  output logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata
);

  localparam logic [2:0] WAIT_INIT = 3'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  lbus_state_e     state_reg, state_next;
  logic            sel_reg, sel_next;
  logic [15:0]     addr_reg, addr_next;
  logic [2:0]      we_reg, we_next;
  logic [XLEN-1:0] wdata_reg, wdata_next;
  logic            resp_valid_reg, resp_valid_next;
  logic [XLEN-1:0] resp_rdata_reg, resp_rdata_next;
  logic            resp_err_reg, resp_err_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic            write_reg, write_next;
  logic [1:0]      size_reg, size_next;
  logic            uns_reg, uns_next;
  logic            err_reg, err_next;
  logic [XLEN-1:0] result_reg, result_next;

  logic            misalign;
  logic            hit;
  logic [XLEN-1:0] aligned_data;

`ifdef LBUS_INITIATOR_MISALIGN_ERR_EN
  assign misalign = ((req_size == LBUS_SZ_HALF) && req_addr[0]) ||
                    ((req_size == LBUS_SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign hit = (req_addr[31:16] == BASE_HI) && (req_size != LBUS_SZ_RSVD) && !misalign;

  // addr_reg still carries the latched offset while the read is in flight.
  lbus_load_align #(.XLEN(XLEN)) u_align (
    .data        (rdata),
    .offset      (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .result      (aligned_data)
  );

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    addr_next       = addr_reg;
    we_next         = we_reg;
    wdata_next      = wdata_reg;
    resp_valid_next = 1'b0;
    resp_rdata_next = '0;
    resp_err_next   = 1'b0;
    cnt_next        = cnt_reg;
    write_next      = write_reg;
    size_next       = size_reg;
    uns_next        = uns_reg;
    err_next        = err_reg;
    result_next     = result_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          write_next  = req_write;
          size_next   = req_size;
          uns_next    = req_unsigned;
          result_next = '0;
          if (hit) begin
            err_next   = 1'b0;
            sel_next   = 1'b1;
            addr_next  = req_addr[15:0];
            we_next    = {req_write, req_size};
            wdata_next = lbus_replicate(req_wdata, req_size);
            state_next = ST_ACCESS;
          end else begin
            err_next   = 1'b1;
            state_next = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        if (write_reg || (RD_LAT == 0)) begin
          if (!write_reg) begin
            result_next = aligned_data;
          end
          sel_next   = 1'b0;
          we_next    = 3'b000;
          state_next = ST_RESP;
        end else begin
          cnt_next   = WAIT_INIT;
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_reg == 3'd0) begin
          result_next = aligned_data;
          sel_next    = 1'b0;
          we_next     = 3'b000;
          state_next  = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end

      ST_RESP: begin
        resp_valid_next = 1'b1;
        resp_err_next   = err_reg;
        resp_rdata_next = (err_reg || write_reg) ? '0 : result_reg;
        state_next      = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= 1'b0;
      addr_reg       <= '0;
      we_reg         <= '0;
      wdata_reg      <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      cnt_reg        <= '0;
      write_reg      <= 1'b0;
      size_reg       <= '0;
      uns_reg        <= 1'b0;
      err_reg        <= 1'b0;
      result_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      addr_reg       <= addr_next;
      we_reg         <= we_next;
      wdata_reg      <= wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      cnt_reg        <= cnt_next;
      write_reg      <= write_next;
      size_reg       <= size_next;
      uns_reg        <= uns_next;
      err_reg        <= err_next;
      result_reg     <= result_next;
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign sel        = sel_reg;
  assign addr       = addr_reg;
  assign we         = we_reg;
  assign wdata      = wdata_reg;

endmodule

// File: doc/lbus_initiator.md
Name: lbus_initiator

Overview:
- Local-bus initiator that turns single load/store requests from the core's LSU into local-bus cycles (sel/addr/we/wdata), and returns read data that has been lane-extracted and sign/zero-extended.
- Sits between the core data port and the peripheral register blocks (timer/CLINT, etc.). It drives the access cycle those responders decode.
- One outstanding transaction at a time; fixed read-latency window.

Parameters:
- XLEN, 32, data width (core_general.vh value; only 32 is supported).
- BASE_HI, 16'h0200, req_addr[31:16] value that maps to this local bus.
- RD_LAT, 1, extra cycles sel is held before rdata is sampled (0..7).

Ports:
- clk  in  1  global clock.
- rst_n  in  1  global reset, synchronous, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  initiator can accept a request.
- req_addr  in  32  byte address.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend load result.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  load result (0 for stores and errors).
- resp_err  out  1  access error, qualified by resp_valid.
- sel  out  1  local-bus select.
- addr  out  16  local-bus address (req_addr[15:0]).
- we  out  3  {write, size}: 3'b110 word, 3'b101 half, 3'b100 byte, 3'b0xx read.
- wdata  out  XLEN  local-bus write data.
- rdata  in  XLEN  local-bus read data (OR of responders, 0 when unselected).

Behaviour:
- Clock and reset:
  - Single clock domain clk. rst_n is synchronous, active-low.
  - Reset: FSM=IDLE; sel=0, addr=0, we=0, wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
- Request acceptance:
  - FSM states IDLE, ACCESS, WAIT, RESP.
  - req_ready=1 only in IDLE. A request is accepted when req_valid&req_ready; addr/size/write/unsigned/wdata are latched.
- Request checks at acceptance:
  - Hit = (req_addr[31:16]==BASE_HI) and req_size!=2'b11.
  - Miss or reserved size: go straight to RESP, resp_err=1, no bus cycle.
  - Otherwise go to ACCESS.
- ACCESS (registered outputs, first cycle after acceptance):
  - sel=1, addr=latched[15:0], we={write,size}.
  - wdata is replicated: byte ×4, half ×2, word as-is.
- Writes:
  - Exactly one sel cycle, then RESP.
- Reads:
  - sel, addr and we are held for RD_LAT further cycles in WAIT, using a 3-bit down-counter.
  - rdata is sampled in the last sel cycle. With RD_LAT=0 it is sampled in the ACCESS cycle.
  - Lane extraction: shift right by 8*addr[1:0]. Half uses addr[1] only.
  - Byte result is extended from bit 7, half from bit 15; sign-extend unless unsigned. Word passes through.
- After every access cycle, sel/we return to 0 and addr holds its value.
- RESP:
  - resp_valid=1 for exactly one cycle; the response is not backpressured.
  - Next state is IDLE; req_ready rises the following cycle.
  - Request-to-response latency: write 3 cycles, read 3+RD_LAT cycles, error 2 cycles, all counted from the acceptance edge.
- Boundaries:
  - Misaligned half/word is aligned down silently (addr[0], or addr[1:0], ignored for extraction).
  - req_valid asserted outside IDLE is ignored.
  - rst_n low mid-transaction aborts it: no resp_valid, sel drops on the next edge.
  - rdata outside the sample cycle is ignored.

Optional Feature:
- Macro: LBUS_INITIATOR_MISALIGN_ERR_EN.
- Defined: a half with addr[0]=1, or a word with addr[1:0]!=0, gets the error path (RESP with resp_err=1, no bus cycle).
- Undefined: silent align-down as described in Behaviour.

Decomposition:
- Shared package/header, lbus_defs.vh:
  - size codes LBUS_SZ_BYTE/HALF/WORD;
  - we encodings LBUS_WE_WORD=3'b110, LBUS_WE_HALF=3'b101, LBUS_WE_BYTE=3'b100;
  - FSM state localparams;
  - CLINT BASE_HI constant.
- One natural sub-module: lbus_load_align, combinational. It does lane shift plus sign/zero extension; reusable by the data-memory path.

Test Plan:
- Word write 0xDEADBEEF to 0x0200_4000, RD_LAT=1:
  - one sel cycle with addr=16'h4000, we=3'b110, wdata=0xDEADBEEF;
  - resp_valid 3 cycles after accept, err=0.
- Byte write 0xA5 to 0x0200_0003:
  - we=3'b100, wdata=0xA5A5A5A5.
- Signed half load from 0x0200_BFFA with rdata=0x8001_1234:
  - sel held 2 cycles, resp_rdata=0xFFFF8001;
  - same load unsigned gives 0x00008001.
- Byte load from 0x0200_0001 with rdata=0x0000_7F00:
  - resp_rdata=0x0000007F;
  - with RD_LAT=0, one sel cycle and latency 3.
- Error paths, sel never asserted in either case:
  - access to 0x1000_0000 gives resp_valid+resp_err 2 cycles after accept;
  - req_size=11 gives the same error response.
- Reset and feature-gated cases:
  - rst_n low during WAIT: no resp_valid, all outputs at reset values, next request behaves normally;
  - with LBUS_INITIATOR_MISALIGN_ERR_EN, word at 0x0200_4002 gives resp_err=1 and no sel.
